// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder
// Brief    : Rate-1/2, K=4 convolutional encoder with framed input and 3-bit
//            zero tail so every frame ends with the trellis in state 000.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder #(
   parameter logic [3:0] G0 = 4'b1011,
   parameter logic [3:0] G1 = 4'b1101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       start,
   input  logic [7:0] frame_len,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] out_sym,
   input  logic       out_ready,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

   localparam logic [1:0] C_TAIL_LEN = 2'd3;

   logic [1:0] r_state;
   logic [1:0] r_tail_cnt;
   logic [2:0] r_sr;
   logic [7:0] r_count;
   logic       r_out_valid;
   logic [1:0] r_out_sym;
   logic       r_frame_done;

   logic       w_slot;
   logic       w_start_ok;
   logic       w_data_acc;
   logic       w_tail_load;
   logic       w_tail_last;
   logic       w_load;
   logic       w_enc_bit;
   logic [3:0] w_v;
   logic [1:0] w_sym;

   // The output register can take a new symbol when empty or being drained.
   assign w_slot      = !r_out_valid || out_ready;
   assign w_start_ok  = enable && start && (r_state == S_IDLE) && !r_frame_done;
   assign w_data_acc  = enable && (r_state == S_DATA) && w_slot && in_valid;
   assign w_tail_load = enable && (r_state == S_TAIL) && w_slot &&
                        (r_tail_cnt != C_TAIL_LEN);
   assign w_tail_last = enable && (r_state == S_TAIL) &&
                        (r_tail_cnt == C_TAIL_LEN) && r_out_valid && out_ready;
   assign w_load      = w_data_acc || w_tail_load;

   assign w_enc_bit = (r_state == S_DATA) ? in_bit : 1'b0;
   assign w_v       = {w_enc_bit, r_sr[0], r_sr[1], r_sr[2]};
   assign w_sym     = {^(w_v & G1), ^(w_v & G0)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_tail_cnt   <= 2'd0;
         r_sr         <= 3'd0;
         r_count      <= 8'd0;
         r_out_valid  <= 1'b0;
         r_out_sym    <= 2'd0;
         r_frame_done <= 1'b0;
      end else if (!enable) begin
         r_state      <= S_IDLE;
         r_tail_cnt   <= 2'd0;
         r_sr         <= 3'd0;
         r_count      <= 8'd0;
         r_out_valid  <= 1'b0;
         r_out_sym    <= 2'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;

         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sym   <= w_sym;
            r_sr        <= {r_sr[1:0], w_enc_bit};
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_sr       <= 3'd0;
                  r_tail_cnt <= 2'd0;
                  r_count    <= frame_len;
                  if (frame_len == 8'd0) begin
                     r_state <= S_TAIL;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_data_acc) begin
                  r_count <= r_count - 8'd1;
                  if (r_count == 8'd1) begin
                     r_state <= S_TAIL;
                  end
               end
            end
            S_TAIL: begin
               // Frame ends only once the last tail symbol has left the block.
               if (w_tail_load) begin
                  r_tail_cnt <= r_tail_cnt + 2'd1;
               end else if (w_tail_last) begin
                  r_tail_cnt   <= 2'd0;
                  r_state      <= S_IDLE;
                  r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = enable && (r_state == S_DATA) && w_slot;
   assign out_valid  = r_out_valid;
   assign out_sym    = r_out_sym;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder
// Brief    : Scoreboard bench for conv_encoder framing, tail and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       enable    = 1'b0;
   logic       start     = 1'b0;
   logic [7:0] frame_len = 8'd0;
   logic       in_valid  = 1'b0;
   logic       in_bit    = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_sym;
   logic       busy;
   logic       frame_done;

   int n_errors = 0;
   int n_checks = 0;

   logic [1:0] exp_q[$];
   logic [1:0] obs_q[$];
   logic [2:0] m_hist;
   int         dc;

   always #5 clk = ~clk;

   conv_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .start      (start),
      .frame_len  (frame_len),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_sym    (out_sym),
      .out_ready  (out_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoder: m_hist[0] is the most recent past bit.
   task automatic model_push(input logic b);
      logic [3:0] v;
      v = {b, m_hist[0], m_hist[1], m_hist[2]};
      exp_q.push_back({^(v & 4'b1101), ^(v & 4'b1011)});
      m_hist = {m_hist[1:0], b};
   endtask

   task automatic run_frame(input int len, input logic [7:0] data, input bit rnd,
                            input int mid_start_at, input bit start_in_tail,
                            output int done_cyc);
      int         idx;
      int         cyc;
      bit         done;
      bit         stalled;
      logic [1:0] held;
      idx      = 0;
      cyc      = 0;
      done     = 0;
      stalled  = 0;
      held     = 2'd0;
      done_cyc = -1;
      obs_q.delete();
      exp_q.delete();
      @(negedge clk);
      start     = 1'b1;
      frame_len = len[7:0];
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      start  = 1'b0;
      m_hist = 3'd0;
      if (len == 0) begin
         for (int k = 0; k < 3; k++) model_push(1'b0);
      end
      while (!done && cyc < 300) begin
         in_valid  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         in_bit    = (idx < 8) ? data[idx] : 1'b0;
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         start     = (cyc == mid_start_at) || (start_in_tail && idx >= len);
         if (cyc == mid_start_at) frame_len = 8'd5;
         #1;
         if (stalled) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_sym", out_sym, held);
         end
         if (out_valid && !out_ready) check_eq("ready_backpressure", in_ready, 0);
         if (in_ready && idx >= len) check_eq("ready_extra", in_ready, 0);
         if (frame_done) begin
            check_eq("done_queue_empty", exp_q.size(), 0);
            check_eq("done_bits", idx, len);
            check_eq("done_busy", busy, 0);
            check_eq("done_outv", out_valid, 0);
            done     = 1;
            done_cyc = cyc;
         end else begin
            if (in_valid && in_ready && idx < len) begin
               model_push(in_bit);
               idx++;
               if (idx == len) begin
                  for (int k = 0; k < 3; k++) model_push(1'b0);
               end
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check_eq("sym_extra", exp_q.size(), 1);
               else check_eq("sym", out_sym, exp_q.pop_front());
               obs_q.push_back(out_sym);
            end
            stalled = out_valid && !out_ready;
            held    = out_sym;
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) check_eq("timeout", done, 1);
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("done_one_cycle", frame_done, 0);
      check_eq("idle_after_done", busy, 0);
   endtask

   initial begin
      #2;
      check_eq("rst_outv", out_valid, 0);
      check_eq("rst_sym", out_sym, 0);
      check_eq("rst_ready", in_ready, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", frame_done, 0);
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b1;

      // Single bit, full rate: 11,10,01,11 then done; start held through tail.
      run_frame(1, 8'h01, 0, -1, 1, dc);
      check_eq("len1_latency", dc, 5);
      check_eq("len1_count", obs_q.size(), 4);
      if (obs_q.size() == 4) begin
         check_eq("len1_s0", obs_q[0], 2'b11);
         check_eq("len1_s1", obs_q[1], 2'b10);
         check_eq("len1_s2", obs_q[2], 2'b01);
         check_eq("len1_s3", obs_q[3], 2'b11);
      end

      // Tail-only frame.
      run_frame(0, 8'h00, 0, -1, 0, dc);
      check_eq("len0_latency", dc, 4);
      check_eq("len0_count", obs_q.size(), 3);

      // Random stalls and bits.
      for (int i = 0; i < 4; i++) begin
         run_frame(8, 8'($urandom), 1, -1, 0, dc);
         check_eq("rnd_count", obs_q.size(), 11);
      end

      // Start during DATA must not retarget the frame.
      run_frame(8, 8'hB5, 0, 2, 0, dc);
      check_eq("midstart_latency", dc, 12);
      check_eq("midstart_count", obs_q.size(), 11);

      // Enable dropped after 3 data bits.
      @(negedge clk);
      start = 1'b1; frame_len = 8'd8; out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
      repeat (3) @(negedge clk);
      enable = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("en_low_ready", in_ready, 0);
      @(negedge clk);
      #1;
      check_eq("en_low_busy", busy, 0);
      check_eq("en_low_outv", out_valid, 0);
      check_eq("en_low_done", frame_done, 0);
      @(negedge clk);
      #1;
      check_eq("en_low_done2", frame_done, 0);
      enable = 1'b1;
      run_frame(8, 8'h6C, 0, -1, 0, dc);
      check_eq("after_en_count", obs_q.size(), 11);

      // Reset while a tail symbol is stalled.
      @(negedge clk);
      start = 1'b1; frame_len = 8'd0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      check_eq("tail_pre_rst_outv", out_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("arst_outv", out_valid, 0);
      check_eq("arst_sym", out_sym, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_ready", in_ready, 0);
      check_eq("arst_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check_eq("post_rst_no_done", frame_done, 0);
      end
      run_frame(3, 8'h05, 0, -1, 0, dc);
      check_eq("post_rst_latency", dc, 7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL have parameter G0, default 4'b1011, meaning generator polynomial for symbol bit 0; bit 3 taps the current input.
REQ-002 The block SHALL have parameter G1, default 4'b1101, meaning generator polynomial for symbol bit 1; bit 3 taps the current input.
REQ-003 The block SHALL have port clk, input, 1, meaning clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port enable, input, 1, meaning synchronous run enable; low aborts and clears.
REQ-006 The block SHALL have port start, input, 1, meaning frame-start pulse, sampled only in IDLE.
REQ-007 The block SHALL have port frame_len, input, 8, meaning number of data bits in the frame, captured on an accepted start.
REQ-008 The block SHALL have ports in_valid (input, 1), in_bit (input, 1) and in_ready (output, 1), meaning the data-bit handshake.
REQ-009 The block SHALL have ports out_valid (output, 1), out_sym (output, 2) and out_ready (input, 1), meaning the coded-symbol handshake.
REQ-010 The block SHALL have port busy, output, 1, meaning high whenever state is not IDLE.
REQ-011 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse after the final tail symbol is accepted.

Function
REQ-012 The block SHALL keep a 3-bit shift register sr (sr[0] = most recent past bit) and, per encoded bit b, form v = {b, sr[0], sr[1], sr[2]}, with out_sym[0] = XOR-reduce(v & G0) and out_sym[1] = XOR-reduce(v & G1), then update sr to {sr[1:0], b}.
REQ-013 The FSM SHALL have states IDLE, DATA and TAIL.
REQ-014 IDLE -> DATA SHALL occur on enable & start with frame_len != 0; remaining count is loaded with frame_len, sr is cleared.
REQ-015 IDLE -> TAIL SHALL occur on enable & start with frame_len == 0, producing a tail-only frame of 3 symbols.
REQ-016 In DATA, in_ready SHALL be high iff (!out_valid | out_ready); a bit is accepted when in_valid & in_ready.
REQ-017 Each accepted bit SHALL load out_sym and set out_valid on the next edge, giving 1-cycle latency.
REQ-018 DATA -> TAIL SHALL occur when the bit that takes the remaining count to 0 is accepted.
REQ-019 TAIL SHALL encode exactly 3 zero bits, one per cycle in which (!out_valid | out_ready), so the trellis ends in state 000.
REQ-020 in_ready SHALL be 0 in IDLE and TAIL.
REQ-021 out_valid and out_sym SHALL hold stable while out_valid & !out_ready, with no symbol loss or duplication.
REQ-022 A full rate SHALL be sustained: one symbol per cycle when in_valid and out_ready are held high.
REQ-023 After the 3rd tail symbol is loaded, the FSM SHALL wait until it is accepted, then pulse frame_done for 1 cycle and return to IDLE.
REQ-024 start SHALL be ignored while busy.
REQ-025 A start in the same cycle as frame_done SHALL be ignored; start is honoured from IDLE only.
REQ-026 enable low in any state SHALL, on the next edge, force IDLE, clear sr and the count, and deassert out_valid; no frame_done is produced.
REQ-027 With enable low, in_ready SHALL be 0.

Reset
REQ-028 While rst is low, the block SHALL asynchronously force state IDLE, sr = 000, count = 0, out_valid = 0, out_sym = 00, in_ready = 0, busy = 0, frame_done = 0.
REQ-029 A reset mid-frame SHALL discard the frame entirely, and the block SHALL accept a new start on the first edge after rst rises.

Verification
REQ-030 The bench SHALL cover: frame_len = 1, in_bit = 1, out_ready held 1 -> out_sym sequence 11, 10, 01, 11 on 4 consecutive cycles, then a frame_done pulse, busy = 0.
REQ-031 The bench SHALL cover: frame_len = 0 -> 3 symbols 00, 00, 00, then frame_done, with in_ready never high.
REQ-032 The bench SHALL cover: frame_len = 8, random bits, out_ready toggled randomly -> 11 symbols matching a software model, each out_sym stable while stalled, in_ready = 0 whenever out_valid & !out_ready.
REQ-033 The bench SHALL cover: start pulsed during DATA with frame_len = 5 -> ignored; the original frame completes with the original length.
REQ-034 The bench SHALL cover: enable dropped after 3 bits of an 8-bit frame -> next cycle busy = 0, out_valid = 0, no frame_done; a new frame then encodes from sr = 000.
REQ-035 The bench SHALL cover: rst asserted while out_valid = 1 in TAIL -> all outputs 0 immediately, no frame_done after rst is released.
